// File: rtl/reflet_float_to_int_seq.sv
// Sequential float -> signed integer converter.
// Accepts one float at a time, classifies it, then shifts the magnitude
// one bit per cycle until the binary point lines up with the integer LSB.
// Results are truncated toward zero and saturate on overflow, inf and NaN.
module reflet_float_to_int_seq #(
    parameter int float_size = 32,
    parameter int int_size   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] float_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [int_size-1:0]   int_out,
    output logic                  overflow,
    output logic                  inexact
);

    // Exponent field width for the supported float formats.
    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    localparam int E  = exponent_size(float_size);
    localparam int M  = float_size - E - 1;
    localparam int B  = (2 ** (E - 1)) - 1;
    localparam int IS = int_size;
    localparam int W  = (IS > M + 1) ? IS : M + 1;
    localparam int CW = $clog2(W + 1);

    localparam logic [IS-1:0] MAX_POS = {1'b0, {(IS-1){1'b1}}};
    localparam logic [IS-1:0] MIN_NEG = {1'b1, {(IS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r, state_n;
    logic            sign_r, sign_n;
    logic            dir_left_r, dir_left_n;
    logic [CW-1:0]   count_r, count_n;
    logic [W-1:0]    mag_r, mag_n;
    logic [IS-1:0]   int_out_r, int_out_n;
    logic            overflow_r, overflow_n;
    logic            inexact_r, inexact_n;
    logic            in_ready_r;
    logic            out_valid_r;

    logic            sign_s;
    logic [E-1:0]    exp_s;
    logic [M-1:0]    mant_s;
    int              e_s;
    logic [IS-1:0]   mag_lo_s;

    assign sign_s   = float_in[float_size-1];
    assign exp_s    = float_in[float_size-2:M];
    assign mant_s   = float_in[M-1:0];
    assign e_s      = int'({1'b0, exp_s}) - B;
    assign mag_lo_s = mag_r[IS-1:0];

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign int_out   = int_out_r;
    assign overflow  = overflow_r;
    assign inexact   = inexact_r;

    // Next-state and datapath: classify on accept, shift in SHIFT, hold in DONE.
    always_comb begin
        state_n    = state_r;
        sign_n     = sign_r;
        dir_left_n = dir_left_r;
        count_n    = count_r;
        mag_n      = mag_r;
        int_out_n  = int_out_r;
        overflow_n = overflow_r;
        inexact_n  = inexact_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    sign_n     = sign_s;
                    int_out_n  = {IS{1'b0}};
                    overflow_n = 1'b0;
                    inexact_n  = 1'b0;
                    if (exp_s == {E{1'b0}}) begin
                        inexact_n = (mant_s != {M{1'b0}});
                        state_n   = DONE;
                    end else if (&exp_s) begin
                        // NaN always maps to max positive; inf follows its sign.
                        if (mant_s != {M{1'b0}}) begin
                            int_out_n = MAX_POS;
                        end else begin
                            int_out_n = sign_s ? MIN_NEG : MAX_POS;
                        end
                        overflow_n = 1'b1;
                        state_n    = DONE;
                    end else if (e_s < 32'sd0) begin
                        inexact_n = 1'b1;
                        state_n   = DONE;
                    end else if ((e_s > IS - 1) ||
                                 ((e_s == IS - 1) && !(sign_s && (mant_s == {M{1'b0}})))) begin
                        int_out_n  = sign_s ? MIN_NEG : MAX_POS;
                        overflow_n = 1'b1;
                        state_n    = DONE;
                    end else if (e_s == IS - 1) begin
                        // Exactly -2^(IS-1): representable, no flags.
                        int_out_n = MIN_NEG;
                        state_n   = DONE;
                    end else begin
                        mag_n = W'({1'b1, mant_s});
                        if (e_s > M) begin
                            dir_left_n = 1'b1;
                            count_n    = CW'(e_s - M);
                        end else begin
                            dir_left_n = 1'b0;
                            count_n    = CW'(M - e_s);
                        end
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (count_r == {CW{1'b0}}) begin
                    int_out_n = sign_r ? ({IS{1'b0}} - mag_lo_s) : mag_lo_s;
                    state_n   = DONE;
                end else if (dir_left_r) begin
                    mag_n   = {mag_r[W-2:0], 1'b0};
                    count_n = count_r - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    // Bits falling off the right end are discarded fraction.
                    mag_n     = {1'b0, mag_r[W-1:1]};
                    inexact_n = inexact_r | mag_r[0];
                    count_n   = count_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            dir_left_r  <= 1'b0;
            count_r     <= {CW{1'b0}};
            mag_r       <= {W{1'b0}};
            int_out_r   <= {IS{1'b0}};
            overflow_r  <= 1'b0;
            inexact_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            sign_r      <= sign_n;
            dir_left_r  <= dir_left_n;
            count_r     <= count_n;
            mag_r       <= mag_n;
            int_out_r   <= int_out_n;
            overflow_r  <= overflow_n;
            inexact_r   <= inexact_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_reflet_float_to_int_seq.sv
// Scoreboard bench for reflet_float_to_int_seq (float_size=32, int_size=16).
module tb_reflet_float_to_int_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] int_out;
    logic        overflow;
    logic        inexact;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] v;
        logic        ovf;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    reflet_float_to_int_seq #(.float_size(32), .int_size(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_in  (float_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .int_out   (int_out),
        .overflow  (overflow),
        .inexact   (inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented result against the queue head.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("FAIL unexpected_output actual=out_valid=1 required=out_valid=0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    check("int_out", {16'd0, int_out}, {16'd0, e.v});
                    check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    check("inexact", {31'd0, inexact}, {31'd0, e.inx});
                    check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Issue one float; called at posedge+1, returns at posedge+1 after accept.
    task automatic send(input logic [31:0] f, input logic [15:0] v, input logic ovf,
                        input logic inx, input int lat, input bit push);
        int   guard;
        exp_t e;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard = guard + 1;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            in_valid = 1'b1;
            float_in = f;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) begin
                e.v   = v;
                e.ovf = ovf;
                e.inx = inx;
                e.lat = lat;
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard = guard + 1;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int guard;
        reset     = 1'b0;
        in_valid  = 1'b0;
        float_in  = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_int_out", {16'd0, int_out}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_inexact", {31'd0, inexact}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: float, int, ovf, inexact, latency.
        send(32'hC2F60000, 16'hFF85, 1'b0, 1'b0, 19, 1'b1);  // -123.0
        send(32'h40490000, 16'h0003, 1'b0, 1'b1, 24, 1'b1);  // 3.140625
        send(32'h3F000000, 16'h0000, 1'b0, 1'b1, 1,  1'b1);  // 0.5
        send(32'h00000000, 16'h0000, 1'b0, 1'b0, 1,  1'b1);  // +0
        send(32'h47000000, 16'h7FFF, 1'b1, 1'b0, 1,  1'b1);  // 32768.0
        send(32'hC7000000, 16'h8000, 1'b0, 1'b0, 1,  1'b1);  // -32768.0
        send(32'h7FC00000, 16'h7FFF, 1'b1, 1'b0, 1,  1'b1);  // NaN
        send(32'hFF800000, 16'h8000, 1'b1, 1'b0, 1,  1'b1);  // -inf
        send(32'h00000001, 16'h0000, 1'b0, 1'b1, 1,  1'b1);  // denormal
        send(32'hC7000080, 16'h8000, 1'b1, 1'b0, 1,  1'b1);  // just below -32768
        send(32'h46FFFE00, 16'h7FFF, 1'b0, 1'b0, 11, 1'b1);  // 32767.0
        send(32'h3F800000, 16'h0001, 1'b0, 1'b0, 25, 1'b1);  // 1.0
        send(32'hBFC00000, 16'hFFFF, 1'b0, 1'b1, 25, 1'b1);  // -1.5
        send(32'hC0000000, 16'hFFFE, 1'b0, 1'b0, 24, 1'b1);  // -2.0
        drain();

        // Back-pressure: hold result 5 cycles, in_valid pulses must be ignored.
        out_ready = 1'b0;
        send(32'h42280000, 16'h002A, 1'b0, 1'b0, 20, 1'b1);  // 42.0
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard = guard + 1;
        end
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
            float_in = 32'h3F800000;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
        drain();
        repeat (30) @(posedge clk);
        #1;

        // Reset pulse in the middle of a shift: nothing must come out.
        send(32'h40490000, 16'h0003, 1'b0, 1'b1, 24, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_int_out", {16'd0, int_out}, 32'd0);
        check("midrst_inexact", {31'd0, inexact}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        send(32'hC2F60000, 16'hFF85, 1'b0, 1'b0, 19, 1'b1);
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
